// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexed Izhikevich Q16.16 neuron sweeper: one shared update datapath, per-neuron v/u arrays.
// Optional per-sweep spike counter output when IZH_SCHED_SPIKE_COUNT_EN is defined.
module izh_neuron_scheduler #(
    parameter int                 N_NEURONS = 16,
    parameter int                 IDX_W     = $clog2(N_NEURONS),
    parameter logic signed [31:0] A         = 32'sd1311,
    parameter logic signed [31:0] B         = 32'sd13107,
    parameter logic signed [31:0] C         = -(32'sd65 <<< 16),
    parameter logic signed [31:0] D         = 32'sd8 <<< 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_valid,
    output logic                    tick_ready,
    output logic                    cur_req,
    output logic [IDX_W-1:0]        cur_idx,
    input  logic                    cur_valid,
    input  logic signed [31:0]      cur_data,
    output logic                    spk_valid,
    output logic [IDX_W-1:0]        spk_idx,
    input  logic                    spk_ready,
    output logic                    busy,
    output logic                    sweep_done,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [31:0]      rd_v
`ifdef IZH_SCHED_SPIKE_COUNT_EN
    ,
    output logic [IDX_W:0]          spike_count
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, COMPUTE, EMIT, DONE} state_t;

    localparam logic signed [63:0] A64    = 64'(A);
    localparam logic signed [63:0] B64    = 64'(B);
    localparam logic signed [63:0] C64    = 64'(C);
    localparam logic signed [31:0] U_RST  = 32'((B64 * C64) >>> 16);
    localparam logic signed [31:0] V_PEAK = 32'sd30 <<< 16;
    localparam logic [IDX_W-1:0]   LAST   = IDX_W'(N_NEURONS - 1);

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic signed [31:0]     i_reg;
    logic signed [31:0]     v_mem [N_NEURONS];
    logic signed [31:0]     u_mem [N_NEURONS];
    logic                   wr_en;

    logic signed [31:0]     v_cur, u_cur, v_upd, u_upd;
    logic signed [63:0]     v64, u64, i64, vv, t1, t2, bv, dv_w, du_w;
    logic                   fired;

    assign v_cur = v_mem[idx_reg];
    assign u_cur = u_mem[idx_reg];
    assign v64   = 64'(v_cur);
    assign u64   = 64'(u_cur);
    assign i64   = 64'(i_reg);
    assign fired = (v_cur >= V_PEAK);

    // 64-bit intermediates; only the final sums are truncated, so overflow wraps rather than saturates
    assign vv    = (v64 * v64) >>> 16;
    assign t1    = (64'sd2621 * vv) >>> 16;
    assign t2    = (64'sd327680 * v64) >>> 16;
    assign dv_w  = t1 + t2 + 64'sd9175040 - u64 + i64;
    assign bv    = (B64 * v64) >>> 16;
    assign du_w  = (A64 * (bv - u64)) >>> 16;
    assign v_upd = fired ? C : v_cur + $signed(dv_w[31:0]);
    assign u_upd = fired ? u_cur + D : u_cur + $signed(du_w[31:0]);

    assign cur_idx = idx_reg;
    assign spk_idx = idx_reg;
    assign rd_v    = v_mem[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            i_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (state_reg == FETCH && cur_valid)
                i_reg <= cur_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= C;
                u_mem[i] <= U_RST;
            end
        end else if (wr_en) begin
            v_mem[idx_reg] <= v_upd;
            u_mem[idx_reg] <= u_upd;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        tick_ready = 1'b0;
        cur_req    = 1'b0;
        spk_valid  = 1'b0;
        sweep_done = 1'b0;
        busy       = 1'b1;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                tick_ready = 1'b1;
                busy       = 1'b0;
                if (tick_valid) begin
                    idx_next   = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                cur_req = 1'b1;
                if (cur_valid)
                    state_next = COMPUTE;
            end
            COMPUTE: begin
                wr_en = 1'b1;
                if (fired)
                    state_next = EMIT;
                else if (idx_reg == LAST)
                    state_next = DONE;
                else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = FETCH;
                end
            end
            EMIT: begin
                spk_valid = 1'b1;
                if (spk_ready) begin
                    if (idx_reg == LAST)
                        state_next = DONE;
                    else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef IZH_SCHED_SPIKE_COUNT_EN
    logic [IDX_W:0] cnt_reg;

    // The visible count only changes at sweep end, so it is stable for the router between sweeps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            spike_count <= '0;
        end else begin
            if (state_reg == IDLE && tick_valid)
                cnt_reg <= '0;
            else if (state_reg == EMIT && spk_ready)
                cnt_reg <= cnt_reg + 1'b1;
            if (state_reg == DONE)
                spike_count <= cnt_reg;
        end
    end
`endif

endmodule

// File: doc/izh_neuron_scheduler.md
Name: izh_neuron_scheduler

Overview:
- Time-multiplexes one Izhikevich Q16.16 update datapath across N_NEURONS neurons.
- Per-neuron v/u state lives in internal register arrays.
- Each accepted tick runs one full sweep: fetch the neuron's input current over a request/valid handshake, compute, write back, and emit spike events over valid/ready.
- Sits between the stimulus/synapse front end and the spike router; replaces N parallel neuron instances.

Parameters:
- N_NEURONS, 16, number of neurons swept; power of two, ≥2.
- IDX_W, $clog2(N_NEURONS), index width.
- A, 32'sd1311, recovery rate (0.02, Q16.16).
- B, 32'sd13107, recovery sensitivity (0.2).
- C, -65<<<16, post-spike reset voltage.
- D, 8<<<16, post-spike recovery increment.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- tick_valid  in  1  request one sweep.
- tick_ready  out  1  high only in IDLE.
- cur_req  out  1  current request for neuron cur_idx.
- cur_idx  out  IDX_W  neuron being processed.
- cur_valid  in  1  cur_data valid; sampled only while cur_req high.
- cur_data  in  32  signed Q16.16 input current I.
- spk_valid  out  1  spike event pending.
- spk_idx  out  IDX_W  index of spiking neuron.
- spk_ready  in  1  spike consumer ready.
- busy  out  1  high in any state other than IDLE.
- sweep_done  out  1  one-cycle pulse at end of sweep.
- rd_idx  in  IDX_W  debug readback index.
- rd_v  out  32  combinational v[rd_idx].

Behaviour:
- Reset (async, active low), asserted at any time including mid-sweep:
  - v[i]=C and u[i]=(B*C)>>>16 for all i (defaults: -4259840 and -851955).
  - FSM to IDLE; idx=0; cur_req, spk_valid, sweep_done, busy = 0.
- FSM states: IDLE, FETCH, COMPUTE, EMIT, DONE.
- IDLE: tick_ready=1. tick_valid&&tick_ready clears idx to 0 and goes to FETCH. tick_valid outside IDLE is not accepted; the source holds it.
- FETCH: cur_req=1, cur_idx=idx. On cur_valid, latch cur_data into I_reg and go to COMPUTE. Otherwise wait indefinitely.
- COMPUTE: read v[idx]/u[idx] and write v_next/u_next at the end of this single cycle.
  - If fired: go to EMIT.
  - Else if idx==N_NEURONS-1: go to DONE.
  - Else: idx+1, go to FETCH.
- EMIT: spk_valid=1, spk_idx=idx, both held stable until spk_ready. On handshake, leave exactly as COMPUTE's non-fired branch does (DONE if idx is last, else idx+1 and FETCH). The sweep stalls while spk_ready is low.
- DONE: sweep_done=1 for one cycle, then IDLE.
- Timing: with cur_valid tied high, spk_ready tied high and no spikes, sweep_done is high in the cycle 2N+1 after the tick handshake. Each spike adds 1 cycle.
- Arithmetic: signed 32-bit Q16.16 with 64-bit intermediates. Truncate to 32 bits with no saturation; overflow wraps.
  - fired = (v ≥ 30<<<16).
  - If fired: v_next=C, u_next=u+D.
  - Else: dv = ((2621*((v*v)>>>16))>>>16) + (((5<<<16)*v)>>>16) + (140<<<16) - u + I.
  - Else: du = (A*(((B*v)>>>16) - u))>>>16.
  - v_next=v+dv, u_next=u+du.
- rd_v reflects the written value from the cycle after the COMPUTE write.

Optional Feature:
- Macro IZH_SCHED_SPIKE_COUNT_EN.
- When defined: adds output spike_count [IDX_W:0].
  - Internal counter clears on tick accept and increments on each EMIT handshake.
  - spike_count updates to the counter value in DONE and holds until the next DONE.
  - Reset value 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with rd_idx swept 0..15 -> rd_v=-4259840 for all i; tick_ready=1, busy=0, spk_valid=0, sweep_done=0.
- One tick, cur_valid=1, cur_data=0 -> cur_idx steps 0..15; sweep_done in cycle 33 after handshake; rd_v=-4458320 for all i; no spk_valid.
- cur_data=1000<<<16 for idx 3 only, others 0, two ticks:
  - After tick 1, rd_v(3) is ≥30<<<16.
  - Tick 2: spk_valid with spk_idx=3. Hold spk_ready=0 for 5 cycles -> FSM stalls, cur_idx stays 3. After the handshake, rd_v(3)=-4259840.
  - With the macro defined, spike_count=1 after tick 2.
- Withhold cur_valid 10 cycles at idx 0 -> cur_req=1 and cur_idx=0 held; no array change; then sweep resumes normally.
- tick_valid held high through a sweep -> tick_ready=0 while busy; the second sweep starts only after return to IDLE.
- Assert reset at idx 7 of a sweep -> same cycle: cur_req=0, busy=0; all rd_v=-4259840; the next tick starts from idx 0.
